rf_op_sequencer: RTL
====================

// Module: rf_op_sequencer
// PURPOSE
//  Micro-sequencer that executes one register-to-register instruction at a time on
//  the 4x8-bit register file (2 async read ports A/B, 1 sync write port W).
//  Accepts instructions over a valid/ready handshake, then drives the read
//  addresses, computes a result, and issues a single write-back.
//  Sits between the instruction source (switch/keypad FSM or test ROM) and the
//  register file; the register file's write port has no other owner.
// PARAMETERS
//  DATA_W  8  register/data width; must match register file width
//  ADDR_W  2  register index width (4 registers)
// PORTS
//  CLOCK_50     in   1       system clock; all state changes on posedge
//  reset        in   1       synchronous, active-high reset
//  instr_valid  in   1       instruction present on instr_* this cycle
//  instr_ready  out  1       sequencer can accept; high only in IDLE
//  instr_op     in   3       opcode (see BEHAVIOUR)
//  instr_rd     in   ADDR_W  destination register
//  instr_rs     in   ADDR_W  source register 1 (read port A)
//  instr_rt     in   ADDR_W  source register 2 (read port B)
//  instr_imm    in   DATA_W  immediate (LDI value; SHL amount in [2:0])
//  rf_regA      out  ADDR_W  register file read address A
//  rf_regB      out  ADDR_W  register file read address B
//  rf_dataA     in   DATA_W  register file read data A (combinational)
//  rf_dataB     in   DATA_W  register file read data B (combinational)
//  rf_regW      out  ADDR_W  register file write address
//  rf_dataW     out  DATA_W  register file write data
//  rf_write     out  1       register file write enable (RFWrite)
//  busy         out  1       high in any state except IDLE
//  done         out  1       one-cycle pulse in WRITE state
//  result       out  DATA_W  last computed result; holds until next WRITE
//  flag_z       out  1       last ALU result was zero
//  flag_c       out  1       carry-out (ADD), borrow (SUB), bit shifted out (SHL)
// BEHAVIOUR
//  Opcodes: 000 NOP; 001 LDI rd<=imm; 010 MOV rd<=rs; 011 ADD rd<=rs+rt;
//   100 SUB rd<=rs-rt; 101 AND rd<=rs&rt; 110 OR rd<=rs|rt; 111 SHL rd<=rs<<imm[2:0].
//  FSM: IDLE -> READ -> EXEC -> WRITE -> IDLE; no stalls, fixed latency.
//  - IDLE: instr_ready=1. On valid&ready, latch op/rd/rs/rt/imm -> READ.
//  - READ: rf_regA=rs, rf_regB=rt; latch rf_dataA/rf_dataB into operand regs.
//  - EXEC: compute DATA_W+1-bit result from latched operands into result reg.
//  - WRITE: rf_regW=rd, rf_dataW=result[DATA_W-1:0], rf_write=1 (0 for NOP),
//    done=1; register file updates at end of this cycle -> IDLE.
//  Latency: handshake at edge N -> rf_write high in cycle N+3 -> ready again N+4.
//  Arithmetic modulo 2^DATA_W; ADD carry = bit DATA_W; SUB borrow = rs<rt
//   (unsigned); SHL by 0 gives c=0; SHL c = last bit shifted out.
//  Flags update in WRITE only for ADD/SUB/AND/OR/SHL; AND/OR clear flag_c;
//   LDI/MOV/NOP leave flags unchanged. result updates for all ops except NOP.
//  rf_regA/rf_regB/rf_regW/rf_dataW hold the latched fields outside their active
//   state (no glitch requirement; rf_write is the only qualifier).
//  instr_valid while busy is ignored (no capture, no error); source must hold.
//  rd equal to rs/rt is legal: operands latched in READ, before the write.
//  Back-to-back dependency: next READ follows previous WRITE edge, so it sees
//   the new value; no forwarding is required.
//  Reset: state->IDLE, rf_write=0, done=0, busy=0, result=0, flag_z=0, flag_c=0,
//   latched fields=0. Reset mid-instruction aborts it with no write; register
//   file contents are not cleared by this block.
// STRUCTURE
//  Package rf_seq_pkg: opcode localparams (OP_NOP..OP_SHL), FSM state encoding
//   (2-bit, IDLE=0 READ=1 EXEC=2 WRITE=3), DATA_W/ADDR_W defaults.
//  Sub-module rf_seq_alu: combinational op/a/b/imm -> {carry, result}, zero flag.
//  Top: FSM, instruction/operand latches, flag regs, register file port muxing.
// TESTING (bench instantiates register_file + rf_op_sequencer)
//  LDI r1,0x2A; LDI r2,0x16 -> r1=0x2A, r2=0x16; each rf_write at handshake+3.
//  ADD r3,r1,r2 -> r3=0x40, z=0, c=0; ADD r0,r3,r3 with r3=0x80 -> r0=0x00, z=1, c=1.
//  SUB r0,r2,r1 (0x16-0x2A) -> r0=0xEC, c=1; then MOV r1,r0 -> r1=0xEC, flags held.
//  instr_valid held high 8 cycles with ADD then LDI -> exactly one accept per
//   4 cycles; second READ sees first result (dependency case).
//  reset pulsed in EXEC of ADD r2,r1,r1 -> no rf_write, r2 unchanged, outputs
//   at reset values next cycle, instr_ready=1.
//  NOP and SHL r1,r1,imm=3 on 0xEC -> NOP: no write, done pulses; SHL: 0x60, c=1.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared opcode, state and width definitions for the register-file
// op sequencer and its ALU.
package rf_seq_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU: result with carry/borrow/shift-out in the top bit,
// plus a zero flag on the low DATA_W bits.
module rf_seq_alu
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W:0]   res_o,
    output logic              zero_o
);

    logic [2*DATA_W-1:0] shl_wide;

    always_comb begin
        // Last bit shifted out of the data word lands at index DATA_W.
        shl_wide = {{DATA_W{1'b0}}, a_i} << imm_i[2:0];
        res_o    = '0;
        unique case (op_i)
            OP_NOP: res_o = '0;
            OP_LDI: res_o = {1'b0, imm_i};
            OP_MOV: res_o = {1'b0, a_i};
            OP_ADD: res_o = {1'b0, a_i} + {1'b0, b_i};
            OP_SUB: res_o = {1'b0, a_i} - {1'b0, b_i};
            OP_AND: res_o = {1'b0, a_i & b_i};
            OP_OR:  res_o = {1'b0, a_i | b_i};
            OP_SHL: res_o = shl_wide[DATA_W:0];
            default: res_o = '0;
        endcase
        zero_o = (res_o[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// Four-state micro-sequencer: accepts one instruction, reads operands from
// the register file, executes it and writes the result back.
module rf_op_sequencer
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs,
    input  logic [ADDR_W-1:0] instr_rt,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [ADDR_W-1:0] rf_regA,
    output logic [ADDR_W-1:0] rf_regB,
    input  logic [DATA_W-1:0] rf_dataA,
    input  logic [DATA_W-1:0] rf_dataB,
    output logic [ADDR_W-1:0] rf_regW,
    output logic [DATA_W-1:0] rf_dataW,
    output logic              rf_write,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_z,
    output logic              flag_c
);

    state_e state_q, state_d;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic [DATA_W:0]   alu_q;
    logic              aluz_q;
    logic [DATA_W-1:0] result_q;
    logic              flag_z_q, flag_c_q;

    logic [DATA_W:0]   alu_res;
    logic              alu_zero;
    logic              accept;
    logic              upd_flags;

    rf_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i   (op_q),
        .a_i    (opa_q),
        .b_i    (opb_q),
        .imm_i  (imm_q),
        .res_o  (alu_res),
        .zero_o (alu_zero)
    );

    assign accept    = instr_valid && (state_q == ST_IDLE);
    assign upd_flags = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                       (op_q == OP_AND) || (op_q == OP_OR)  ||
                       (op_q == OP_SHL);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (instr_valid) state_d = ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            op_q     <= OP_NOP;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            alu_q    <= '0;
            aluz_q   <= 1'b0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= instr_op;
                rd_q  <= instr_rd;
                rs_q  <= instr_rs;
                rt_q  <= instr_rt;
                imm_q <= instr_imm;
            end
            if (state_q == ST_READ) begin
                opa_q <= rf_dataA;
                opb_q <= rf_dataB;
            end
            if (state_q == ST_EXEC) begin
                alu_q  <= alu_res;
                aluz_q <= alu_zero;
            end
            // Architectural result/flags only move at write-back.
            if (state_q == ST_WRITE && op_q != OP_NOP) begin
                result_q <= alu_q[DATA_W-1:0];
                if (upd_flags) begin
                    flag_z_q <= aluz_q;
                    flag_c_q <= alu_q[DATA_W];
                end
            end
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_WRITE);
    assign rf_write    = (state_q == ST_WRITE) && (op_q != OP_NOP);
    assign rf_regA     = rs_q;
    assign rf_regB     = rt_q;
    assign rf_regW     = rd_q;
    assign rf_dataW    = alu_q[DATA_W-1:0];
    assign result      = result_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

endmodule
